cpu_issue_scoreboard: RTL

// - Issue controller between decode and execute: gates each decoded instruction on register hazards.
// - Tracks outstanding writes to GPRs x1..x31 from multi-cycle ops (loads, complex ALU) with per-register counters.
// - Holds decode while a source register is pending; drains the pipeline for serializing ops (CSR/fence).

---
 rtl/cpu_issue_scoreboard.sv | 90 +++++++++
 1 files changed

// File: rtl/cpu_issue_scoreboard.sv
// cpu_issue_scoreboard: gates decoded instructions on register hazards from in-flight long writes.
// Optional ISSUE_WB_BYPASS_EN makes a same-cycle writeback visible to the hazard and serialize checks.
module cpu_issue_scoreboard #(
  parameter int CNT_W   = 2,
  parameter int OUTST_W = 6
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [2:0]         i_have_rs,
  input  logic [4:0]         i_rs1,
  input  logic [4:0]         i_rs2,
  input  logic [4:0]         i_rs3,
  input  logic [4:0]         i_rd,
  input  logic               i_rd_write,
  input  logic               i_long,
  input  logic               i_serialize,
  input  logic               i_exec_ready,
  input  logic               i_flush,
  input  logic               i_wb_valid,
  input  logic [4:0]         i_wb_rd,
  output logic               o_issue,
  output logic               o_stall,
  output logic [1:0]         o_state,
  output logic [OUTST_W-1:0] o_outstanding,
  output logic               o_fault
);
  typedef enum logic [1:0] {RUN = 2'd0, HAZARD = 2'd1, SERIAL = 2'd2} state_t;
  localparam logic [CNT_W-1:0]   CMAX = '1;
  localparam logic [OUTST_W-1:0] OMAX = '1;
  logic [CNT_W-1:0]   pend_q [32];
  logic [CNT_W-1:0]   pend_d [32];
  logic [OUTST_W-1:0] outst_q, outst_d;
  logic               fault_q, fault_d;
  state_t             state_q;
  logic [31:0]        busy;
  logic               hazard, sat, ser_block, inc, dec, wb_bad, ovf;
  always_comb begin
    dec    = i_wb_valid & |i_wb_rd & |pend_q[i_wb_rd];
    wb_bad = i_wb_valid & |i_wb_rd & ~|pend_q[i_wb_rd];
    for (int r = 0; r < 32; r++)
`ifdef ISSUE_WB_BYPASS_EN
      busy[r] = |pend_q[r] & ~(dec & (i_wb_rd == 5'(r)) & (pend_q[r] == CNT_W'(1)));
`else
      busy[r] = |pend_q[r];
`endif
    hazard = (i_have_rs[0] & |i_rs1 & busy[i_rs1]) |
             (i_have_rs[1] & |i_rs2 & busy[i_rs2]) |
             (i_have_rs[2] & |i_rs3 & busy[i_rs3]);
    sat    = i_long & i_rd_write & |i_rd & (pend_q[i_rd] == CMAX);
`ifdef ISSUE_WB_BYPASS_EN
    ser_block = i_serialize & (outst_q != OUTST_W'(dec));
`else
    ser_block = i_serialize & |outst_q;
`endif
    o_issue = i_valid & ~i_flush & i_exec_ready & ~hazard & ~sat & ~ser_block;
    o_stall = i_valid & ~i_flush & ~o_issue;
    inc     = o_issue & i_long & i_rd_write & |i_rd;
    // The global count is held on overflow rather than wrapping; the fault flags it.
    ovf     = inc & ~dec & (outst_q == OMAX);
    outst_d = ovf ? outst_q : outst_q + OUTST_W'(inc) - OUTST_W'(dec);
    fault_d = fault_q | wb_bad | ovf;
    for (int r = 0; r < 32; r++)
      pend_d[r] = pend_q[r] + CNT_W'(inc & (i_rd == 5'(r))) - CNT_W'(dec & (i_wb_rd == 5'(r)));
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pend_q  <= '{default: '0};
      outst_q <= '0;
      fault_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      outst_q <= outst_d;
      fault_q <= fault_d;
    end
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= RUN;
    else case (state_q)
      RUN:     state_q <= (i_valid & ~i_flush & ser_block) ? SERIAL :
                          (o_stall & (hazard | sat)) ? HAZARD : RUN;
      HAZARD:  state_q <= (o_issue | i_flush | ~i_valid) ? RUN : HAZARD;
      SERIAL:  state_q <= (o_issue | i_flush) ? RUN : SERIAL;
      default: state_q <= RUN;
    endcase
  end
  assign o_state       = state_q;
  assign o_outstanding = outst_q;
  assign o_fault       = fault_q;
endmodule
